// File: rtl/load_bins_sequencer.sv
// Load_bins sequencer: decodes edge-triggered load/clear strobes from the
// software register word and drives a valid/ready write port into the
// channel-to-bin table. A load performs one write; a clear walks every
// channel writing bin 0. Commands arriving while busy are counted as drops.
module load_bins_sequencer #(
    parameter int CH_W  = 8,
    parameter int BIN_W = 12
) (
    input  logic             user_clk,
    input  logic             user_rst_n,
    input  logic [31:0]      user_data_in,
    output logic             bin_wr_valid,
    input  logic             bin_wr_ready,
    output logic [CH_W-1:0]  bin_wr_addr,
    output logic [BIN_W-1:0] bin_wr_data,
    output logic             busy,
    output logic [15:0]      load_count,
    output logic [7:0]       drop_count,
    output logic             clear_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_CLEAR
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic             r_prev_ld;
    logic             r_prev_clr;
    logic             w_ld_edge;
    logic             w_clr_edge;
    logic             w_hs;
    logic             w_last_addr;
    logic [1:0]       w_drop_inc;
    logic [8:0]       w_drop_sum;
    logic [CH_W-1:0]  w_cmd_ch;
    logic [BIN_W-1:0] w_cmd_bin;
    logic             w_unused;

    assign w_ld_edge   = user_data_in[31] & ~r_prev_ld;
    assign w_clr_edge  = user_data_in[30] & ~r_prev_clr;
    assign w_cmd_ch    = user_data_in[BIN_W+CH_W-1:BIN_W];
    assign w_cmd_bin   = user_data_in[BIN_W-1:0];
    assign w_hs        = bin_wr_valid & bin_wr_ready;
    assign w_last_addr = (bin_wr_addr == '1);
    assign w_drop_sum  = {1'b0, drop_count} + {7'd0, w_drop_inc};
    // Bits between the channel field and the strobes carry no meaning.
    assign w_unused    = ^user_data_in;

    // State register.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and number of strobe edges to count as dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_drop_inc  = 2'd0;
        case (r_state)
            S_IDLE: begin
                if (w_clr_edge) begin
                    // Clear has priority; a coincident load is discarded.
                    w_state_nxt = S_CLEAR;
                    w_drop_inc  = {1'b0, w_ld_edge};
                end else if (w_ld_edge) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                w_drop_inc = {1'b0, w_ld_edge} + {1'b0, w_clr_edge};
                if (w_hs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CLEAR: begin
                w_drop_inc = {1'b0, w_ld_edge} + {1'b0, w_clr_edge};
                if (w_hs && w_last_addr) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Registered outputs: write port, counters, status and strobe history.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            r_prev_ld    <= 1'b1;
            r_prev_clr   <= 1'b1;
            bin_wr_valid <= 1'b0;
            bin_wr_addr  <= '0;
            bin_wr_data  <= '0;
            busy         <= 1'b0;
            load_count   <= '0;
            drop_count   <= '0;
            clear_done   <= 1'b0;
        end else begin
            r_prev_ld  <= user_data_in[31];
            r_prev_clr <= user_data_in[30];
            clear_done <= 1'b0;
            busy       <= (w_state_nxt != S_IDLE);
            drop_count <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
            case (r_state)
                S_IDLE: begin
                    if (w_clr_edge) begin
                        bin_wr_valid <= 1'b1;
                        bin_wr_addr  <= '0;
                        bin_wr_data  <= '0;
                    end else if (w_ld_edge) begin
                        bin_wr_valid <= 1'b1;
                        bin_wr_addr  <= w_cmd_ch;
                        bin_wr_data  <= w_cmd_bin;
                    end
                end
                S_WRITE: begin
                    if (w_hs) begin
                        bin_wr_valid <= 1'b0;
                        load_count   <= load_count + 16'd1;
                    end
                end
                S_CLEAR: begin
                    if (w_hs) begin
                        if (w_last_addr) begin
                            bin_wr_valid <= 1'b0;
                            clear_done   <= 1'b1;
                        end else begin
                            bin_wr_addr <= bin_wr_addr + 1'b1;
                        end
                    end
                end
                default: begin
                    bin_wr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_bins_sequencer.sv
// Bench for load_bins_sequencer: directed scenarios followed by random
// strobes/backpressure, all checked against a transaction-queue model.
module tb_load_bins_sequencer;

    localparam int CH_W  = 8;
    localparam int BIN_W = 12;
    localparam int NCHAN = 1 << CH_W;

    logic             clk;
    logic             user_rst_n;
    logic [31:0]      user_data_in;
    logic             bin_wr_valid;
    logic             bin_wr_ready;
    logic [CH_W-1:0]  bin_wr_addr;
    logic [BIN_W-1:0] bin_wr_data;
    logic             busy;
    logic [15:0]      load_count;
    logic [7:0]       drop_count;
    logic             clear_done;

    load_bins_sequencer #(.CH_W(CH_W), .BIN_W(BIN_W)) dut (
        .user_clk     (clk),
        .user_rst_n   (user_rst_n),
        .user_data_in (user_data_in),
        .bin_wr_valid (bin_wr_valid),
        .bin_wr_ready (bin_wr_ready),
        .bin_wr_addr  (bin_wr_addr),
        .bin_wr_data  (bin_wr_data),
        .busy         (busy),
        .load_count   (load_count),
        .drop_count   (drop_count),
        .clear_done   (clear_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: queue of writes still owed to the table.
    typedef struct {
        int unsigned addr;
        int unsigned data;
        bit          is_clr;
    } wr_t;

    wr_t         q[$];
    bit          m_p31;
    bit          m_p30;
    int unsigned m_load;
    int unsigned m_drop;
    bit          m_done;

    int n_checks;
    int n_errors;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input bit ld, input bit clr,
                                       input int unsigned ch, input int unsigned bin);
        logic [31:0] w;
        w = 32'd0;
        w[31] = ld;
        w[30] = clr;
        w = w | ((ch % NCHAN) << BIN_W) | (bin % (1 << BIN_W));
        return w;
    endfunction

    task automatic model_reset();
        q.delete();
        m_p31  = 1'b1;
        m_p30  = 1'b1;
        m_load = 0;
        m_drop = 0;
        m_done = 1'b0;
    endtask

    task automatic add_drop(input int unsigned n);
        m_drop = (m_drop + n > 255) ? 255 : m_drop + n;
    endtask

    task automatic model_update(input logic [31:0] w, input bit r);
        bit  ld_e;
        bit  clr_e;
        wr_t e;
        ld_e   = w[31] && !m_p31;
        clr_e  = w[30] && !m_p30;
        m_p31  = w[31];
        m_p30  = w[30];
        m_done = 1'b0;
        if (q.size() != 0) begin
            add_drop(int'(ld_e) + int'(clr_e));
            if (r) begin
                e = q.pop_front();
                if (q.size() == 0) begin
                    if (e.is_clr) m_done = 1'b1;
                    else          m_load = (m_load + 1) % 65536;
                end
            end
        end else if (clr_e) begin
            if (ld_e) add_drop(1);
            for (int unsigned i = 0; i < NCHAN; i++) q.push_back('{i, 0, 1'b1});
        end else if (ld_e) begin
            q.push_back('{(w >> BIN_W) % NCHAN, w % (1 << BIN_W), 1'b0});
        end
    endtask

    task automatic compare();
        bit ev;
        ev = (q.size() != 0);
        chk("valid", bin_wr_valid, ev);
        chk("busy", busy, ev);
        if (ev) begin
            chk("addr", bin_wr_addr, q[0].addr);
            chk("data", bin_wr_data, q[0].data);
        end
        chk("load_count", load_count, m_load);
        chk("drop_count", drop_count, m_drop);
        chk("clear_done", clear_done, m_done);
    endtask

    // Entered and left at a falling edge; one rising edge in between.
    task automatic step(input logic [31:0] w, input bit r);
        compare();
        user_data_in = w;
        bin_wr_ready = r;
        @(posedge clk);
        model_update(w, r);
        @(negedge clk);
    endtask

    // Asynchronous reset asserted away from the clock edge.
    task automatic do_reset(input logic [31:0] w);
        user_data_in = w;
        bin_wr_ready = 1'b0;
        user_rst_n   = 1'b0;
        #1;
        chk("rst_valid", bin_wr_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", bin_wr_addr, 0);
        chk("rst_data", bin_wr_data, 0);
        chk("rst_load", load_count, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_done", clear_done, 0);
        model_reset();
        @(negedge clk);
        user_rst_n = 1'b1;
    endtask

    int          nb;
    int          nd;
    bit          found;
    logic [31:0] rw;

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        user_rst_n   = 1'b0;
        user_data_in = 32'd0;
        bin_wr_ready = 1'b0;
        model_reset();
        @(negedge clk);

        // Strobes already high at reset release must not fire.
        do_reset(32'hC000_0000);
        repeat (5) step(32'hC000_0000, 1'b1);
        step(32'h0, 1'b1);
        step(32'h8000_0000, 1'b1);
        repeat (3) step(32'h0, 1'b1);
        chk("req034_load", load_count, 1);

        // Single load, ready high.
        step(32'h8000_5ABC, 1'b1);
        repeat (3) step(32'h8000_5ABC, 1'b1);
        chk("req030_load", load_count, 2);

        // Backpressure on a load to the top channel.
        step(32'h0, 1'b0);
        step(mk(1, 0, 8'hFF, 12'h001), 1'b0);
        repeat (10) step(mk(1, 0, 8'hFF, 12'h001), 1'b0);
        step(mk(1, 0, 8'hFF, 12'h001), 1'b1);
        step(32'h0, 1'b1);
        chk("req031_load", load_count, 3);

        // Full table clear with ready high.
        step(32'h0, 1'b1);
        step(32'h4000_0000, 1'b1);
        nb = 0;
        nd = 0;
        for (int i = 0; i < 300; i++) begin
            if (busy === 1'b1) nb++;
            if (clear_done === 1'b1) nd++;
            step(32'h4000_0000, 1'b1);
        end
        chk("req032_busy_cycles", nb, NCHAN);
        chk("req032_done_pulses", nd, 1);

        // Load edge during clear, then simultaneous load+clear in idle.
        step(32'h0, 1'b1);
        step(32'h4000_0000, 1'b1);
        step(32'hC000_0000, 1'b1);
        for (int i = 0; i < 300; i++) step(32'h0, 1'b1);
        step(32'hC000_0000, 1'b1);
        chk("req033_drop", drop_count, 2);
        for (int i = 0; i < 300; i++) step(32'h0, 1'b1);
        chk("req033_load", load_count, 3);

        // Random strobes, payloads and backpressure.
        rw = 32'h0;
        for (int i = 0; i < 3000; i++) begin
            rw[29:0] = $urandom;
            if ($urandom_range(0, 7) == 0)  rw[31] = ~rw[31];
            if ($urandom_range(0, 15) == 0) rw[30] = ~rw[30];
            step(rw, $urandom_range(0, 3) != 0);
        end

        // Reset in the middle of a clear, then drop counter saturation.
        do_reset(32'h0);
        step(32'h0, 1'b1);
        step(32'h4000_0000, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (q.size() != 0 && q[0].addr == 100) found = 1'b1;
            else step(32'h4000_0000, 1'b1);
        end
        chk("req035_reach_addr100", found, 1);
        chk("req035_addr_before_rst", bin_wr_addr, 100);
        do_reset(32'h4000_0000);
        nd = 0;
        for (int i = 0; i < 300; i++) begin
            if (clear_done === 1'b1) nd++;
            step(32'h4000_0000, 1'b1);
        end
        chk("req035_no_done", nd, 0);
        step(32'h0, 1'b0);
        step(32'h8000_0000, 1'b0);
        for (int i = 0; i < 300; i++) begin
            step(32'h0, 1'b0);
            step(32'h8000_0000, 1'b0);
        end
        chk("req035_drop_sat", drop_count, 255);
        repeat (3) step(32'h0, 1'b1);
        chk("req035_load", load_count, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
